// File: rtl/data_mem_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dump_ctrl_if
//  Description : Signal bundle between the data memory dump sequencer, the
//                debug unit (request/status), the MEM stage debug read port
//                and the debug UART word stream (valid/ready).
//                The master modport is the sequencer's view; the slave
//                modport is the surrounding system's view.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_mem_dump_ctrl_if #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32
);

  // Debug unit request / pipeline halt handshake
  logic                      i_dump_start;
  logic                      i_pipeline_halted;
  logic                      o_halt_req;

  // MEM stage debug read port (asynchronous read)
  logic [31:0]               o_mem_addr;
  logic [DATA_WIDTH-1:0]     i_mem_data;

  // Dumped word stream
  logic [DATA_WIDTH-1:0]     o_word;
  logic [MEM_ADDR_WIDTH-1:0] o_word_addr;
  logic                      o_word_valid;
  logic                      i_word_ready;

  // Status
  logic                      o_busy;
  logic                      o_done;
  logic                      o_abort;

  modport master (
    input  i_dump_start,
    input  i_pipeline_halted,
    input  i_mem_data,
    input  i_word_ready,
    output o_halt_req,
    output o_mem_addr,
    output o_word,
    output o_word_addr,
    output o_word_valid,
    output o_busy,
    output o_done,
    output o_abort
  );

  modport slave (
    output i_dump_start,
    output i_pipeline_halted,
    output i_mem_data,
    output i_word_ready,
    input  o_halt_req,
    input  o_mem_addr,
    input  o_word,
    input  o_word_addr,
    input  o_word_valid,
    input  o_busy,
    input  o_done,
    input  o_abort
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dump_ctrl
//  Description : Dumps the whole data memory to the debug unit. On a start
//                pulse it requests a pipeline halt, waits for the halt, then
//                walks every word address on the MEM stage debug read port,
//                captures each word and hands it out on a valid/ready stream.
//                Losing the halt mid-dump aborts the dump.
//  Options     : DATA_MEM_DUMP_SKIP_ZERO_EN - when defined, zero words are
//                skipped (the last word is always emitted so the end of the
//                stream stays visible).
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_dump_ctrl #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32
) (
  input  wire logic            i_clk,
  input  wire logic            i_reset_n,
  data_mem_dump_ctrl_if.master bus
);

  // Word index counter width: byte address minus the two always-zero LSBs.
  localparam int c_IDX_WIDTH = MEM_ADDR_WIDTH - 2;
  // Zero padding that lifts the byte address to the 32-bit debug bus.
  localparam int c_ADDR_PAD  = 32 - MEM_ADDR_WIDTH;

  localparam logic [c_IDX_WIDTH-1:0] c_IDX_ONE  = c_IDX_WIDTH'(1);
  localparam logic [c_IDX_WIDTH-1:0] c_IDX_LAST = {c_IDX_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_ADDR      = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_SEND      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_t                    r_state;
  logic                      r_halt_req;
  logic [c_IDX_WIDTH-1:0]    r_idx;
  logic [DATA_WIDTH-1:0]     r_word;
  logic [MEM_ADDR_WIDTH-1:0] r_word_addr;
  logic                      r_word_valid;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_abort;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t                    w_state_nxt;
  logic                      w_halt_req_nxt;
  logic [c_IDX_WIDTH-1:0]    w_idx_nxt;
  logic [DATA_WIDTH-1:0]     w_word_nxt;
  logic [MEM_ADDR_WIDTH-1:0] w_word_addr_nxt;
  logic                      w_word_valid_nxt;
  logic                      w_busy_nxt;
  logic                      w_done_nxt;
  logic                      w_abort_nxt;

  logic                      w_last;
  logic                      w_walking;
  logic                      w_halt_lost;
  logic                      w_skip;

  // The address currently presented is the final word of memory.
  assign w_last      = (r_idx == c_IDX_LAST);
  // States in which the pipeline must stay frozen for the read to be valid.
  assign w_walking   = (r_state == ST_ADDR) || (r_state == ST_CAPTURE) ||
                       (r_state == ST_SEND);
  assign w_halt_lost = w_walking && !bus.i_pipeline_halted;

`ifdef DATA_MEM_DUMP_SKIP_ZERO_EN
  // Zero words are not worth sending, except the final one which marks the end.
  assign w_skip = (bus.i_mem_data == '0) && !w_last;
`else
  assign w_skip = 1'b0;
`endif

  // State register and registered outputs; reset clears everything at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_halt_req   <= 1'b0;
      r_idx        <= '0;
      r_word       <= '0;
      r_word_addr  <= '0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_halt_req   <= w_halt_req_nxt;
      r_idx        <= w_idx_nxt;
      r_word       <= w_word_nxt;
      r_word_addr  <= w_word_addr_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_abort      <= w_abort_nxt;
    end
  end

  // Next-state and next-output decode for the dump sequence.
  always_comb begin
    w_state_nxt      = r_state;
    w_halt_req_nxt   = r_halt_req;
    w_idx_nxt        = r_idx;
    w_word_nxt       = r_word;
    w_word_addr_nxt  = r_word_addr;
    w_word_valid_nxt = r_word_valid;
    w_done_nxt       = 1'b0;
    w_abort_nxt      = 1'b0;

    if (w_halt_lost) begin
      // Halt dropped under us: the read data can no longer be trusted, so
      // give up immediately, even if a transfer would happen this cycle.
      w_state_nxt      = ST_IDLE;
      w_word_valid_nxt = 1'b0;
      w_halt_req_nxt   = 1'b0;
      w_abort_nxt      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_dump_start) begin
            w_state_nxt    = ST_HALT_WAIT;
            w_halt_req_nxt = 1'b1;
            w_idx_nxt      = '0;
          end
        end

        ST_HALT_WAIT: begin
          // No timeout: the pipeline may take arbitrarily long to drain.
          if (bus.i_pipeline_halted) begin
            w_state_nxt = ST_ADDR;
          end
        end

        ST_ADDR: begin
          // Settle cycle so the asynchronous read has a full cycle to resolve.
          w_state_nxt = ST_CAPTURE;
        end

        ST_CAPTURE: begin
          if (w_skip) begin
            w_idx_nxt   = r_idx + c_IDX_ONE;
            w_state_nxt = ST_ADDR;
          end else begin
            w_word_nxt       = bus.i_mem_data;
            w_word_addr_nxt  = {r_idx, 2'b00};
            w_word_valid_nxt = 1'b1;
            w_state_nxt      = ST_SEND;
          end
        end

        ST_SEND: begin
          // Word, address and valid hold until the consumer takes the word.
          if (bus.i_word_ready) begin
            w_word_valid_nxt = 1'b0;
            if (w_last) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt   = r_idx + c_IDX_ONE;
              w_state_nxt = ST_ADDR;
            end
          end
        end

        ST_DONE: begin
          w_halt_req_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end

        default: begin
          w_state_nxt      = ST_IDLE;
          w_halt_req_nxt   = 1'b0;
          w_word_valid_nxt = 1'b0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Debug read address: word aligned, everything above the memory range is 0.
  assign bus.o_mem_addr   = {{c_ADDR_PAD{1'b0}}, r_idx, 2'b00};
  assign bus.o_halt_req   = r_halt_req;
  assign bus.o_word       = r_word;
  assign bus.o_word_addr  = r_word_addr;
  assign bus.o_word_valid = r_word_valid;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_abort      = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_dump_ctrl
//  Description : Directed self-checking bench for data_mem_dump_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_dump_ctrl;

  localparam int MAW = 8;
  localparam int DW  = 32;
  localparam int NW  = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_mem_dump_ctrl_if #(.MEM_ADDR_WIDTH(MAW), .DATA_WIDTH(DW)) bus ();

  data_mem_dump_ctrl #(.MEM_ADDR_WIDTH(MAW), .DATA_WIDTH(DW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  logic [31:0] mem [NW];
  assign bus.i_mem_data = mem[bus.o_mem_addr[7:2]];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          tr_n      = 0;
  logic [7:0]  tr_addr [1024];
  logic [31:0] tr_data [1024];
  int          tr_cyc  [1024];
  int          done_cnt  = 0;
  int          abort_cnt = 0;
  bit          addr_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer / pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_word_valid && bus.i_word_ready && tr_n < 1024) begin
        tr_addr[tr_n] = bus.o_word_addr;
        tr_data[tr_n] = bus.o_word;
        tr_cyc[tr_n]  = cyc;
        tr_n++;
      end
      if (bus.o_done)  done_cnt++;
      if (bus.o_abort) abort_cnt++;
      if ((bus.o_mem_addr & ~32'h0000_00FC) != 32'h0) addr_bad = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_halt_req"},   32'(bus.o_halt_req),   32'h0);
    chk({tag, "_mem_addr"},   bus.o_mem_addr,        32'h0);
    chk({tag, "_word"},       bus.o_word,            32'h0);
    chk({tag, "_word_addr"},  32'(bus.o_word_addr),  32'h0);
    chk({tag, "_word_valid"}, 32'(bus.o_word_valid), 32'h0);
    chk({tag, "_busy"},       32'(bus.o_busy),       32'h0);
    chk({tag, "_done"},       32'(bus.o_done),       32'h0);
    chk({tag, "_abort"},      32'(bus.o_abort),      32'h0);
  endtask

  task automatic pulse_start;
    bus.i_dump_start = 1'b1;
    tick;
    bus.i_dump_start = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = bus.o_word_valid;
    for (int i = 0; i < lim && !ok; i++) begin
      tick;
      ok = bus.o_word_valid;
    end
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = bus.o_done;
    for (int i = 0; i < lim && !ok; i++) begin
      tick;
      ok = bus.o_done;
    end
  endtask

  // Transfers base..base+n-1 must be words 0..n-1 in order with memory data.
  task automatic check_order(input string tag, input int base, input int n);
    int bad;
    bad = 0;
    chk({tag, "_count"}, 32'(tr_n - base), 32'(n));
    for (int k = 0; k < n && (base + k) < 1024; k++) begin
      if (tr_addr[base + k] !== 8'(k * 4) || tr_data[base + k] !== mem[k]) bad++;
    end
    chk({tag, "_order_errors"}, 32'(bad), 32'h0);
  endtask

  initial begin
    bit ok;
    int base;
    int d0;
    int a0;

    bus.i_dump_start      = 1'b0;
    bus.i_pipeline_halted = 1'b0;
    bus.i_word_ready      = 1'b0;
    for (int w = 0; w < NW; w++) mem[w] = 32'(w) * 32'h0101_0101;
`ifdef DATA_MEM_DUMP_SKIP_ZERO_EN
    mem[0] = 32'h5A5A_5A5A;
`endif

    // ---------------- reset state ----------------
    repeat (3) tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // IDLE ignores halted/ready without a start pulse
    bus.i_pipeline_halted = 1'b1;
    bus.i_word_ready      = 1'b1;
    tick;
    tick;
    chk("idle_busy",     32'(bus.o_busy),       32'h0);
    chk("idle_halt_req", 32'(bus.o_halt_req),   32'h0);
    chk("idle_valid",    32'(bus.o_word_valid), 32'h0);

    // ---------------- full dump, no backpressure ----------------
    base = tr_n;
    d0   = done_cnt;
    pulse_start;
    chk("full_halt_req", 32'(bus.o_halt_req),   32'h1);
    chk("full_busy",     32'(bus.o_busy),       32'h1);
    chk("full_valid_c1", 32'(bus.o_word_valid), 32'h0);
    tick;
    chk("full_valid_c2", 32'(bus.o_word_valid), 32'h0);
    tick;
    chk("full_valid_c3", 32'(bus.o_word_valid), 32'h0);
    tick;
    chk("full_valid_c4",  32'(bus.o_word_valid), 32'h1);
    chk("full_first_addr", 32'(bus.o_word_addr), 32'h0);
    chk("full_first_word", bus.o_word,            mem[0]);
    wait_done(400, ok);
    chk("full_done_seen", 32'(ok), 32'h1);
    chk("full_done_count_at_done", 32'(tr_n - base), 32'd64);
    chk("full_done_latency", 32'(cyc - tr_cyc[base + 63]), 32'd1);
    chk("full_done_halt_req", 32'(bus.o_halt_req), 32'h1);
    tick;
    chk("full_after_done",     32'(bus.o_done),     32'h0);
    chk("full_after_halt_req", 32'(bus.o_halt_req), 32'h0);
    chk("full_after_busy",     32'(bus.o_busy),     32'h0);
    chk("full_done_pulses", 32'(done_cnt - d0), 32'h1);
    check_order("full", base, NW);
    chk("full_throughput", 32'(tr_cyc[base + 63] - tr_cyc[base]), 32'd189);
    chk("full_addr_alignment", 32'(addr_bad), 32'h0);

    // ---------------- backpressure on word 2 ----------------
    bus.i_word_ready = 1'b0;
    base = tr_n;
    d0   = done_cnt;
    pulse_start;
    for (int w = 0; w < NW; w++) begin
      wait_valid(10, ok);
      if (!ok) begin
        chk("bp_valid_timeout", 32'h0, 32'h1);
        break;
      end
      if (w == 2) begin
        for (int h = 0; h < 5; h++) begin
          chk("bp_hold_word",  bus.o_word,            32'h0202_0202);
          chk("bp_hold_addr",  32'(bus.o_word_addr),  32'h08);
          chk("bp_hold_valid", 32'(bus.o_word_valid), 32'h1);
          tick;
        end
      end
      bus.i_word_ready = 1'b1;
      tick;
      bus.i_word_ready = 1'b0;
    end
    wait_done(10, ok);
    chk("bp_done_seen", 32'(ok), 32'h1);
    tick;
    check_order("bp", base, NW);
    chk("bp_done_pulses", 32'(done_cnt - d0), 32'h1);

    // ---------------- halt handshake ----------------
    bus.i_pipeline_halted = 1'b0;
    bus.i_word_ready      = 1'b1;
    base = tr_n;
    pulse_start;
    for (int i = 0; i < 10; i++) begin
      chk("hw_halt_req", 32'(bus.o_halt_req),   32'h1);
      chk("hw_valid",    32'(bus.o_word_valid), 32'h0);
      chk("hw_busy",     32'(bus.o_busy),       32'h1);
      tick;
    end
    bus.i_pipeline_halted = 1'b1;
    tick;
    tick;
    chk("hw_valid_before", 32'(bus.o_word_valid), 32'h0);
    tick;
    chk("hw_valid_first", 32'(bus.o_word_valid), 32'h1);
    chk("hw_first_addr",  32'(bus.o_word_addr),  32'h0);
    wait_done(400, ok);
    chk("hw_done_seen", 32'(ok), 32'h1);
    tick;
    check_order("hw", base, NW);

    // ---------------- abort while word 5 is in SEND ----------------
    bus.i_word_ready = 1'b0;
    d0 = done_cnt;
    a0 = abort_cnt;
    pulse_start;
    for (int w = 0; w < 5; w++) begin
      wait_valid(10, ok);
      bus.i_word_ready = 1'b1;
      tick;
      bus.i_word_ready = 1'b0;
    end
    wait_valid(10, ok);
    chk("ab_word5_valid", 32'(ok), 32'h1);
    chk("ab_word5_addr",  32'(bus.o_word_addr), 32'h14);
    bus.i_pipeline_halted = 1'b0;
    bus.i_word_ready      = 1'b1;
    tick;
    chk("ab_abort",    32'(bus.o_abort),      32'h1);
    chk("ab_valid",    32'(bus.o_word_valid), 32'h0);
    chk("ab_halt_req", 32'(bus.o_halt_req),   32'h0);
    chk("ab_busy",     32'(bus.o_busy),       32'h0);
    chk("ab_done",     32'(bus.o_done),       32'h0);
    bus.i_word_ready = 1'b0;
    tick;
    chk("ab_abort_pulse_end", 32'(bus.o_abort), 32'h0);
    repeat (3) tick;
    chk("ab_abort_pulses", 32'(abort_cnt - a0), 32'h1);
    chk("ab_no_done",      32'(done_cnt - d0),  32'h0);
    bus.i_pipeline_halted = 1'b1;

    // ---------------- restart ignored, reset at word 10 ----------------
    bus.i_word_ready = 1'b1;
    base = tr_n;
    pulse_start;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_word_valid && bus.o_word_addr == 8'h28) begin
        ok = 1'b1;
        break;
      end
      bus.i_dump_start = (i == 12);
      tick;
    end
    bus.i_dump_start = 1'b0;
    chk("rs_reached_word10", 32'(ok), 32'h1);
    check_order("rs", base, 10);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    base = tr_n;
    d0   = done_cnt;
    pulse_start;
    tick;
    tick;
    tick;
    chk("rs_fresh_valid", 32'(bus.o_word_valid), 32'h1);
    chk("rs_fresh_addr",  32'(bus.o_word_addr),  32'h0);
    chk("rs_fresh_word",  bus.o_word,            mem[0]);
    wait_done(400, ok);
    chk("rs_done_seen", 32'(ok), 32'h1);
    tick;
    check_order("rs_fresh", base, NW);

`ifdef DATA_MEM_DUMP_SKIP_ZERO_EN
    // ---------------- zero skipping ----------------
    for (int w = 0; w < NW; w++) mem[w] = 32'h0;
    mem[3] = 32'hDEAD_BEEF;
    base = tr_n;
    pulse_start;
    wait_done(400, ok);
    chk("sz_done_seen", 32'(ok), 32'h1);
    chk("sz_count", 32'(tr_n - base), 32'd2);
    chk("sz_addr0", 32'(tr_addr[base]),     32'h0C);
    chk("sz_data0", tr_data[base],          32'hDEAD_BEEF);
    chk("sz_addr1", 32'(tr_addr[base + 1]), 32'hFC);
    chk("sz_data1", tr_data[base + 1],      32'h0);
    tick;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
